// File: rtl/arm7tdmi_pkg.sv
// Shared types, op2 field positions and a rotate helper for the ARM7TDMI
// operand2 datapath.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_t;

  typedef enum logic [1:0] {
    OP2_IDLE,
    OP2_RS_WAIT,
    OP2_DONE
  } op2_state_t;

  localparam int unsigned SHIFT_IMM_MSB  = 11;
  localparam int unsigned SHIFT_IMM_LSB  = 7;
  localparam int unsigned SHIFT_TYPE_MSB = 6;
  localparam int unsigned SHIFT_TYPE_LSB = 5;
  localparam int unsigned SHIFT_REG_BIT  = 4;
  localparam int unsigned RS_MSB         = 11;
  localparam int unsigned RS_LSB         = 8;

  function automatic logic [31:0] ror32(input logic [31:0] d, input logic [4:0] r);
    return (d >> r) | (d << (6'd32 - {1'b0, r}));
  endfunction

endpackage

// File: rtl/arm7tdmi_shift_core.sv
// Combinational ARM barrel shifter: LSL/LSR/ASR/ROR including the immediate #0
// encodings (LSR/ASR #32, RRX) and 8-bit register amounts of 32 and above.
module arm7tdmi_shift_core
  import arm7tdmi_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_type,
  input  logic [7:0]  i_amount,
  input  logic        i_imm_encoding,
  input  logic        i_carry,
  output logic [31:0] o_data,
  output logic        o_carry
);

  shift_type_t w_type;
  logic [7:0]  w_amt;
  logic [4:0]  w_r;
  logic [32:0] w_lsl;
  logic [32:0] w_lsr;
  logic [32:0] w_asr;
  logic [31:0] w_ror;

  assign w_type = shift_type_t'(i_type);

  always_comb begin
    // Immediate LSR/ASR #0 stand for a shift by 32.
    w_amt = i_amount;
    if (i_imm_encoding && (i_amount == 8'd0) &&
        ((w_type == SHIFT_LSR) || (w_type == SHIFT_ASR))) begin
      w_amt = 8'd32;
    end
    w_r   = w_amt[4:0];
    w_lsl = {1'b0, i_data} << w_amt[5:0];
    w_lsr = {i_data, 1'b0} >> w_amt[5:0];
    w_asr = 33'($signed({i_data, 1'b0}) >>> w_amt[5:0]);
    w_ror = ror32(i_data, w_r);

    o_data  = i_data;
    o_carry = i_carry;
    if (i_imm_encoding && (w_type == SHIFT_ROR) && (i_amount == 8'd0)) begin
      o_data  = {i_carry, i_data[31:1]};
      o_carry = i_data[0];
    end else if (w_amt != 8'd0) begin
      unique case (w_type)
        SHIFT_LSL: begin
          if (w_amt <= 8'd32) begin
            {o_carry, o_data} = w_lsl;
          end else begin
            o_data  = 32'd0;
            o_carry = 1'b0;
          end
        end
        SHIFT_LSR: begin
          if (w_amt <= 8'd32) begin
            {o_data, o_carry} = w_lsr;
          end else begin
            o_data  = 32'd0;
            o_carry = 1'b0;
          end
        end
        SHIFT_ASR: begin
          if (w_amt < 8'd32) begin
            {o_data, o_carry} = w_asr;
          end else begin
            o_data  = {32{i_data[31]}};
            o_carry = i_data[31];
          end
        end
        SHIFT_ROR: begin
          if (w_r == 5'd0) begin
            o_data  = i_data;
            o_carry = i_data[31];
          end else begin
            o_data  = w_ror;
            o_carry = w_ror[31];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arm7tdmi_operand2_unit.sv
// Data-processing operand2 unit: immediate rotate, immediate shift and
// register-specified shift with a sequenced Rs read.
module arm7tdmi_operand2_unit
  import arm7tdmi_pkg::*;
#(
  parameter int unsigned RS_READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_imm,
  input  logic [11:0] req_op2,
  input  logic [31:0] req_rm_data,
  input  logic        req_carry,
  input  logic        flush,
  output logic        rs_rd_en,
  output logic [3:0]  rs_addr,
  input  logic [31:0] rs_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_carry
);

  localparam logic [1:0] LAST_CNT = 2'(RS_READ_LAT - 1);

  op2_state_t  r_state, w_state_d;
  logic [1:0]  r_cnt, w_cnt_d;
  logic [31:0] r_rm;
  logic        r_carry;
  logic [1:0]  r_type;
  logic [3:0]  r_rs_addr;
  logic [31:0] r_res_data;
  logic        r_res_carry;

  logic        w_idle, w_accept, w_reg_shift, w_cnt_done, w_load;
  logic [31:0] w_imm_rot, w_core_data, w_res;
  logic        w_core_carry, w_res_c;
  logic        w_unused_rs;

  assign w_idle      = (r_state == OP2_IDLE);
  assign w_accept    = w_idle && req_valid && !flush;
  assign w_reg_shift = !req_imm && req_op2[SHIFT_REG_BIT];
  assign w_cnt_done  = (r_state == OP2_RS_WAIT) && (r_cnt == LAST_CNT);
  assign w_load      = (w_accept && !w_reg_shift) || (w_cnt_done && !flush);
  assign w_unused_rs = ^rs_data[31:8];

  assign w_imm_rot = ror32({24'd0, req_op2[7:0]}, {req_op2[RS_MSB:RS_LSB], 1'b0});

  // In IDLE the core sees the live request; in RS_WAIT it sees the latched one.
  arm7tdmi_shift_core u_shift_core (
    .i_data         (w_idle ? req_rm_data : r_rm),
    .i_type         (w_idle ? req_op2[SHIFT_TYPE_MSB:SHIFT_TYPE_LSB] : r_type),
    .i_amount       (w_idle ? {3'd0, req_op2[SHIFT_IMM_MSB:SHIFT_IMM_LSB]} : rs_data[7:0]),
    .i_imm_encoding (w_idle),
    .i_carry        (w_idle ? req_carry : r_carry),
    .o_data         (w_core_data),
    .o_carry        (w_core_carry)
  );

  always_comb begin
    w_res   = w_core_data;
    w_res_c = w_core_carry;
    if (w_idle && req_imm) begin
      w_res   = w_imm_rot;
      w_res_c = (req_op2[RS_MSB:RS_LSB] == 4'd0) ? req_carry : w_imm_rot[31];
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      OP2_IDLE: begin
        if (w_accept) begin
          w_state_d = w_reg_shift ? OP2_RS_WAIT : OP2_DONE;
        end
      end
      OP2_RS_WAIT: begin
        if (w_cnt_done) begin
          w_state_d = OP2_DONE;
          w_cnt_d   = 2'd0;
        end else begin
          w_cnt_d = r_cnt + 2'd1;
        end
      end
      OP2_DONE: begin
        if (res_ready) begin
          w_state_d = OP2_IDLE;
        end
      end
      default: w_state_d = OP2_IDLE;
    endcase
    if (flush) begin
      w_state_d = OP2_IDLE;
      w_cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= OP2_IDLE;
      r_cnt       <= 2'd0;
      r_rm        <= 32'd0;
      r_carry     <= 1'b0;
      r_type      <= 2'd0;
      r_rs_addr   <= 4'd0;
      r_res_data  <= 32'd0;
      r_res_carry <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_rm      <= req_rm_data;
        r_carry   <= req_carry;
        r_type    <= req_op2[SHIFT_TYPE_MSB:SHIFT_TYPE_LSB];
        r_rs_addr <= req_op2[RS_MSB:RS_LSB];
      end
      if (w_load) begin
        r_res_data  <= w_res;
        r_res_carry <= w_res_c;
      end
    end
  end

  assign req_ready = w_idle;
  assign res_valid = (r_state == OP2_DONE);
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign rs_rd_en  = w_accept && w_reg_shift;
  assign rs_addr   = (w_idle && req_valid) ? req_op2[RS_MSB:RS_LSB] : r_rs_addr;

endmodule

// File: tb/tb_arm7tdmi_operand2_unit.sv
// Directed bench: instance 0 uses RS_READ_LAT=1, instance 1 uses RS_READ_LAT=2.
module tb_arm7tdmi_operand2_unit;

  typedef struct {
    logic        imm;
    logic [11:0] op2;
    logic [31:0] rm;
    logic        c;
    logic [31:0] rs;
    logic [31:0] exp_d;
    logic        exp_c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_imm [2];
  logic [11:0] req_op2 [2];
  logic [31:0] req_rm_data [2];
  logic        req_carry [2];
  logic        flush [2];
  logic        rs_rd_en [2];
  logic [3:0]  rs_addr [2];
  logic [31:0] rs_data [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [31:0] res_data [2];
  logic        res_carry [2];

  logic [31:0] rs_val;
  logic [31:0] p1 [2];
  logic [31:0] p2 [2];
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs [18];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    arm7tdmi_operand2_unit #(.RS_READ_LAT(g + 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_imm    (req_imm[g]),
      .req_op2    (req_op2[g]),
      .req_rm_data(req_rm_data[g]),
      .req_carry  (req_carry[g]),
      .flush      (flush[g]),
      .rs_rd_en   (rs_rd_en[g]),
      .rs_addr    (rs_addr[g]),
      .rs_data    (rs_data[g]),
      .res_valid  (res_valid[g]),
      .res_ready  (res_ready[g]),
      .res_data   (res_data[g]),
      .res_carry  (res_carry[g])
    );
  end

  // Register file model: data valid exactly RS_READ_LAT cycles after the strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      p1[k] <= rs_rd_en[k] ? rs_val : 32'hDEADBEEF;
      p2[k] <= p1[k];
    end
  end
  assign rs_data[0] = p1[0];
  assign rs_data[1] = p2[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input int s, input logic imm, input logic [11:0] op2,
                       input logic [31:0] rm, input logic c, input logic [31:0] rs,
                       output int lat);
    logic reg_sh;
    reg_sh = !imm && op2[4];
    @(negedge clk);
    req_valid[s] = 1'b1; req_imm[s] = imm; req_op2[s] = op2;
    req_rm_data[s] = rm; req_carry[s] = c; rs_val = rs;
    #1;
    chk("req_ready_at_accept", 32'(req_ready[s]), 32'd1);
    chk("rs_rd_en_at_accept", 32'(rs_rd_en[s]), 32'(reg_sh));
    if (reg_sh) chk("rs_addr", 32'(rs_addr[s]), 32'(op2[11:8]));
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0; req_rm_data[s] = 32'hBAD0BAD0; req_carry[s] = ~c;
    req_op2[s] = 12'hFFF; rs_val = 32'h5A5A5A5A;
    chk("rs_rd_en_one_cycle", 32'(rs_rd_en[s]), 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (res_valid[s]) break;
    end
  endtask

  task automatic finish_op(input int s);
    @(negedge clk);
    res_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    res_ready[s] = 1'b0;
    chk("idle_after_xfer", {30'd0, res_valid[s], req_ready[s]}, 32'd1);
  endtask

  task automatic check_reset(input int s);
    chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
    chk("rst_res_valid", 32'(res_valid[s]), 32'd0);
    chk("rst_rs_rd_en", 32'(rs_rd_en[s]), 32'd0);
    chk("rst_rs_addr", 32'(rs_addr[s]), 32'd0);
    chk("rst_res_data", res_data[s], 32'd0);
    chk("rst_res_carry", 32'(res_carry[s]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] held_d;
    logic        held_c;
    // imm, op2, rm, carry_in, rs, expected data, expected carry
    vecs[0]  = '{1'b1, 12'h4FF, 32'h0,        1'b0, 32'h0,   32'hFF000000, 1'b1};
    vecs[1]  = '{1'b1, 12'h0AB, 32'h0,        1'b1, 32'h0,   32'h000000AB, 1'b1};
    vecs[2]  = '{1'b0, 12'h020, 32'h80000001, 1'b1, 32'h0,   32'h00000000, 1'b1};
    vecs[3]  = '{1'b0, 12'h040, 32'h80000001, 1'b1, 32'h0,   32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{1'b0, 12'h060, 32'h80000001, 1'b1, 32'h0,   32'hC0000000, 1'b1};
    vecs[5]  = '{1'b0, 12'h000, 32'h80000001, 1'b1, 32'h0,   32'h80000001, 1'b1};
    vecs[6]  = '{1'b0, 12'h200, 32'h12345678, 1'b0, 32'h0,   32'h23456780, 1'b1};
    vecs[7]  = '{1'b0, 12'h420, 32'h12345678, 1'b1, 32'h0,   32'h00123456, 1'b0};
    vecs[8]  = '{1'b0, 12'h240, 32'h80000018, 1'b0, 32'h0,   32'hF8000001, 1'b1};
    vecs[9]  = '{1'b0, 12'h460, 32'h12345678, 1'b1, 32'h0,   32'h78123456, 1'b0};
    vecs[10] = '{1'b0, 12'h310, 32'h80000001, 1'b0, 32'd32,  32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 12'h330, 32'h80000001, 1'b0, 32'd33,  32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 12'h350, 32'h80000001, 1'b0, 32'd200, 32'hFFFFFFFF, 1'b1};
    vecs[13] = '{1'b0, 12'h370, 32'h80000001, 1'b0, 32'd64,  32'h80000001, 1'b1};
    vecs[14] = '{1'b0, 12'h390, 32'h80000001, 1'b0, 32'd0,   32'h80000001, 1'b0};
    vecs[15] = '{1'b0, 12'h510, 32'h80000001, 1'b1, 32'h104, 32'h00000010, 1'b0};
    vecs[16] = '{1'b0, 12'h670, 32'h80000001, 1'b1, 32'd31,  32'h00000003, 1'b0};
    vecs[17] = '{1'b0, 12'h730, 32'h80000001, 1'b0, 32'd1,   32'h40000000, 1'b1};

    rst_n = 1'b0;
    rs_val = 32'h0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_imm[k] = 1'b0; req_op2[k] = 12'h0;
      req_rm_data[k] = 32'h0; req_carry[k] = 1'b0; flush[k] = 1'b0; res_ready[k] = 1'b0;
    end
    #12;
    check_reset(0);
    check_reset(1);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      do_op(0, vecs[i].imm, vecs[i].op2, vecs[i].rm, vecs[i].c, vecs[i].rs, lat);
      chk($sformatf("latency_v%0d", i), 32'(lat),
          (vecs[i].imm || !vecs[i].op2[4]) ? 32'd1 : 32'd2);
      chk($sformatf("data_v%0d", i), res_data[0], vecs[i].exp_d);
      chk($sformatf("carry_v%0d", i), 32'(res_carry[0]), 32'(vecs[i].exp_c));
      finish_op(0);
    end

    // Backpressure: result must hold while res_ready stays low.
    do_op(0, 1'b0, 12'h330, 32'h80000001, 1'b0, 32'd1, lat);
    chk("bp_latency", 32'(lat), 32'd2);
    held_d = res_data[0];
    held_c = res_carry[0];
    chk("bp_data", held_d, 32'h40000000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_data", res_data[0], 32'h40000000);
      chk("bp_hold_carry", 32'(res_carry[0]), 32'(held_c));
      chk("bp_valid_ready", {30'd0, res_valid[0], req_ready[0]}, 32'd2);
    end
    finish_op(0);
    do_op(0, 1'b1, 12'h4FF, 32'h0, 1'b0, 32'h0, lat);
    chk("post_bp_latency", 32'(lat), 32'd1);
    chk("post_bp_data", res_data[0], 32'hFF000000);
    finish_op(0);

    // Flush during RS_WAIT on the two-cycle Rs instance.
    @(negedge clk);
    req_valid[1] = 1'b1; req_imm[1] = 1'b0; req_op2[1] = 12'h330;
    req_rm_data[1] = 32'h80000001; req_carry[1] = 1'b0; rs_val = 32'd1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    flush[1] = 1'b1;
    @(posedge clk);
    #1 flush[1] = 1'b0;
    chk("flush_idle", {30'd0, res_valid[1], req_ready[1]}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_no_valid", 32'(res_valid[1]), 32'd0);
    end
    // A request coincident with flush must not be taken.
    @(negedge clk);
    req_valid[1] = 1'b1; flush[1] = 1'b1;
    #1 chk("flush_blocks_rd_en", 32'(rs_rd_en[1]), 32'd0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0; flush[1] = 1'b0;
    chk("flush_blocks_accept", {30'd0, res_valid[1], req_ready[1]}, 32'd1);
    do_op(1, 1'b0, 12'h730, 32'h80000001, 1'b0, 32'd1, lat);
    chk("lat2_latency", 32'(lat), 32'd3);
    chk("lat2_data", res_data[1], 32'h40000000);
    chk("lat2_carry", 32'(res_carry[1]), 32'd1);
    finish_op(1);
    do_op(1, 1'b0, 12'h350, 32'h80000001, 1'b0, 32'd200, lat);
    chk("lat2_asr_data", res_data[1], 32'hFFFFFFFF);
    finish_op(1);

    // Asynchronous reset while holding a result in DONE.
    do_op(0, 1'b1, 12'h4FF, 32'h0, 1'b0, 32'h0, lat);
    chk("pre_rst_valid", 32'(res_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(res_valid[0]), 32'd0);
    chk("async_rst_ready", 32'(req_ready[0]), 32'd1);
    chk("async_rst_data", res_data[0], 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(0, 1'b0, 12'h310, 32'h80000001, 1'b0, 32'd32, lat);
    chk("post_rst_latency", 32'(lat), 32'd2);
    chk("post_rst_data", res_data[0], 32'h0);
    chk("post_rst_carry", 32'(res_carry[0]), 32'd1);
    finish_op(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arm7tdmi_operand2_unit.md
Name: arm7tdmi_operand2_unit

Overview:
- Produces the data-processing second operand (shifter_operand, shifter_carry) from the 12-bit operand2 field, the I bit and Rm data.
- Handles immediate-rotate, immediate-shift and register-specified shift. For register-specified shift it sequences the Rs register read, which is the extra internal cycle.
- Implements full ARM shift semantics, including the #0 special encodings and 8-bit Rs amounts of 32 and above.
- Sits between decode/register-read and the ALU.

Parameters:
- RS_READ_LAT, 1, cycles from rs_rd_en to a valid rs_data. Legal values are 1 and 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  operand request
- req_ready  out  1  unit can accept a request
- req_imm  in  1  I bit of the instruction
- req_op2  in  12  instruction bits [11:0]
- req_rm_data  in  32  Rm value, already PC-adjusted by the caller
- req_carry  in  1  CPSR C flag
- flush  in  1  abort the in-flight request
- rs_rd_en  out  1  Rs read strobe
- rs_addr  out  4  Rs register index, equal to op2[11:8]
- rs_data  in  32  Rs read data
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  32  shifter operand
- res_carry  out  1  shifter carry-out

Behaviour:
- Reset values: state IDLE; req_ready=1; res_valid=0; rs_rd_en=0; rs_addr=0; res_data=0; res_carry=0.
- Handshake: a request is accepted when req_valid&&req_ready; the unit latches op2, I, rm_data and carry. A result transfers when res_valid&&res_ready.
- While res_valid=1 and res_ready=0, res_data and res_carry hold stable.
- States: IDLE, RS_WAIT, DONE. req_ready=1 only in IDLE.
- IDLE, request accepted, I=1 or op2[4]=0: compute and register the result. Next cycle enter DONE with res_valid=1, giving latency 1.
- IDLE, request accepted, I=0 and op2[4]=1: in the accept cycle drive rs_rd_en=1 for one cycle and rs_addr=op2[11:8], then enter RS_WAIT.
- RS_WAIT: a counter runs RS_READ_LAT cycles. Capture rs_data[7:0] as amt, compute, and enter DONE. Latency is RS_READ_LAT+1.
- DONE: on res_ready go to IDLE. There is no back-to-back accept in the same cycle, so throughput is one request per 2 or more cycles.
- flush: in any state, next state is IDLE, res_valid=0 and the counter clears. A request presented in the same cycle as flush is not accepted.
- Immediate rotate (I=1): rot=2*op2[11:8] and res=op2[7:0] ROR rot. If rot==0 then C=req_carry, else C=res[31].
- Immediate shift (I=0, op2[4]=0): amount is op2[11:7], type is op2[6:5] (LSL/LSR/ASR/ROR).
  - LSL #0: res=rm, C=carry_in.
  - LSR #0 means LSR #32: res=0, C=rm[31].
  - ASR #0 means ASR #32: res={32{rm[31]}}, C=rm[31].
  - ROR #0 means RRX: res={carry_in,rm[31:1]}, C=rm[0].
  - Nonzero amount n: standard shift, with C = the last bit shifted out (rm[32-n] for LSL, rm[n-1] otherwise).
- Register shift (amt = 8 bits, 0..255); op2[7] is ignored. If amt==0: res=rm, C=carry_in for every type.
  - LSL: amt<32 standard. amt==32 gives res=0, C=rm[0]. amt>32 gives res=0, C=0.
  - LSR: amt<32 standard. amt==32 gives res=0, C=rm[31]. amt>32 gives res=0, C=0.
  - ASR: amt>=32 gives res={32{rm[31]}}, C=rm[31].
  - ROR: if amt[4:0]==0, res=rm and C=rm[31]. Otherwise rotate by amt[4:0] with C=rm[amt[4:0]-1].
- carry_in is the latched req_carry throughout.

Decomposition:
- arm7tdmi_pkg holds the existing shift_type_t, plus:
  - op2_state_t {OP2_IDLE, OP2_RS_WAIT, OP2_DONE};
  - field-position localparams for op2: SHIFT_IMM_MSB=11, SHIFT_IMM_LSB=7, SHIFT_TYPE_MSB=6, SHIFT_TYPE_LSB=5, SHIFT_REG_BIT=4, RS_MSB=11, RS_LSB=8.
- One combinational sub-module, arm7tdmi_shift_core. Inputs: data, type, 8-bit amount, an imm_encoding flag, carry_in. Outputs: data, carry. It implements the special-case table above.
- The FSM, the latch registers and the RS_READ_LAT counter live in arm7tdmi_operand2_unit.

Test Plan:
- Immediate rotate: I=1, op2=0x4FF (rot=4, so rotate by 8), carry_in=0 -> 1 cycle later res=0xFF000000, C=1. Then op2=0x0AB with carry_in=1 -> res=0x000000AB, C=1.
- Immediate specials, rm=0x80000001, carry_in=1:
  - LSR#0 -> res=0, C=1.
  - ASR#0 -> res=0xFFFFFFFF, C=1.
  - ROR#0 (RRX) -> res=0xC0000000, C=1.
  - LSL#0 -> res=0x80000001, C=1.
- Register shift, RS_READ_LAT=1, rm=0x80000001, carry_in=0:
  - rs_rd_en pulses in the accept cycle with the correct rs_addr; res_valid arrives 2 cycles after accept.
  - rs=32, LSL -> res=0, C=1.
  - rs=33, LSR -> res=0, C=0.
  - rs=200, ASR -> res=0xFFFFFFFF, C=1.
  - rs=64, ROR -> res=rm, C=1.
  - rs=0 -> res=rm, C=0.
- Backpressure: hold res_ready=0 for 5 cycles -> res_data and res_carry stable, req_ready=0. Raise res_ready -> IDLE next cycle, and the next request is accepted.
- Flush during RS_WAIT with RS_READ_LAT=2 -> IDLE next cycle, no res_valid. A fresh request then completes with correct values.
- Asynchronous reset asserted mid-DONE -> res_valid=0 and req_ready=1 immediately. After deassertion the unit is fully functional.
